// File: rtl/m_axi_cmd_pkg.sv
// Shared types and constants for the command-to-AXI master.
package m_axi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  // Response status codes returned to the local controller
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_IDERR   = 2'b01;
  localparam logic [1:0] ST_SLVERR  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // AXI response encodings
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // States in which the watchdog runs (waiting on the slave)
  function automatic logic is_bus_state(input state_e s);
    return (s == WR) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/m_axi_cmd_master_watchdog.sv
// Cycle counter that flags when a bus state has lasted TIMEOUT_CYCLES cycles.
module axi_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic areset,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear takes priority so a fresh state always starts counting from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/m_axi_cmd_master.sv
// Single-beat AXI initiator: one local command in, one AXI transfer, one response out.
module m_axi_cmd_master
  import m_axi_cmd_pkg::*;
#(
  parameter int           DATA_WIDTH     = 32,
  parameter int           ADDR_WIDTH     = 32,
  parameter logic [3:0]   TXN_ID         = 4'h1,
  parameter int           TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [3:0]            cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_status_o,
  output logic [3:0]            awid_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [3:0]            wid_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [3:0]            bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [3:0]            arid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [3:0]            rid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [3:0]            rstrb_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic                  arvalid_q, arvalid_d, bready_q, bready_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            wstrb_q, wstrb_d, id_q, id_d;
  logic [1:0]            status_q, status_d;
  logic                  wd_expired, aw_fin, w_fin;

  // Single-beat reads carry no information in these
  logic unused_inputs;
  assign unused_inputs = ^{rstrb_i, rlast_i};

  axi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .areset    (areset),
    .clr       (state_d != state_q),
    .en        (is_bus_state(state_q)),
    .expired_o (wd_expired)
  );

  // Next-state and output register inputs; a handshake always beats the watchdog
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    id_d        = id_q;
    aw_fin      = aw_done_q || (awvalid_q && awready_i);
    w_fin       = w_done_q || (wvalid_q && wready_i);

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr_i;
          rdata_d     = '0;
          status_d    = ST_OK;
          if (cmd_write_i) begin
            wdata_d   = cmd_wdata_i;
            wstrb_d   = cmd_wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        if (awvalid_q && awready_i) awvalid_d = 1'b0;
        if (wvalid_q && wready_i) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else if (wd_expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wlast_d   = 1'b0;
          status_d  = ST_TIMEOUT;
          state_d   = RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_i && bready_q) begin
          bready_d = 1'b0;
          if (bid_i != TXN_ID)    status_d = ST_IDERR;
          else if (bresp_i != OKAY) status_d = ST_SLVERR;
          else                    status_d = ST_OK;
          state_d = RESP;
        end else if (wd_expired) begin
          bready_d = 1'b0;
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else if (wd_expired) begin
          arvalid_d = 1'b0;
          status_d  = ST_TIMEOUT;
          state_d   = RESP;
        end
      end
      RD_DATA: begin
        if (rvalid_i && rready_q) begin
          rready_d = 1'b0;
          rdata_d  = rdata_i;
          status_d = (rid_i != TXN_ID) ? ST_IDERR : ST_OK;
          state_d  = RESP;
        end else if (wd_expired) begin
          rready_d = 1'b0;
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      RESP: begin
        // rsp_valid rises one cycle after entry, giving the extra register stage
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      status_q    <= ST_OK;
      id_q        <= TXN_ID;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      id_q        <= id_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_status_o = status_q;
  assign awid_o       = id_q;
  assign wid_o        = id_q;
  assign arid_o       = id_q;
  assign awaddr_o     = addr_q;
  assign araddr_o     = addr_q;
  assign awvalid_o    = awvalid_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;
  assign wlast_o      = wlast_q;
  assign wvalid_o     = wvalid_q;
  assign bready_o     = bready_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;

endmodule

// File: tb/tb_m_axi_cmd_master.sv
// Directed and randomized bench for m_axi_cmd_master with a delay-programmable slave.
module tb_m_axi_cmd_master;

  localparam int TO = 8;
  localparam logic [3:0] ID = 4'h1;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic [3:0]  cmd_wstrb_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_status_o;
  logic [3:0]  awid_o, wid_o, arid_o, wstrb_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o;
  logic        awvalid_o, awready_i = 1'b0, wlast_o, wvalid_o, wready_i = 1'b0;
  logic [3:0]  bid_i = '0, rid_i = '0;
  logic [1:0]  bresp_i = '0;
  logic        bvalid_i = 1'b0, bready_o, arvalid_o, arready_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        rvalid_i = 1'b0, rready_o;

  m_axi_cmd_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TXN_ID(ID), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_status_o(rsp_status_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rstrb_i(4'hF), .rlast_i(1'b1),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Slave configuration: each ready/valid comes after N cycles of the master waiting
  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [3:0]  cfg_bid = 4'h1, cfg_rid = 4'h1;
  logic [31:0] cfg_rdata = '0;
  bit          cfg_stray = 1'b0;

  // What the slave observed during the current transaction
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_hi, w_hi, ar_hi, wlast_bad;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb, cap_awid, cap_wid, cap_arid;

  task automatic clear_monitors();
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0; wlast_bad = 0;
    cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0;
    cap_wstrb = '0; cap_awid = '0; cap_wid = '0; cap_arid = '0;
  endtask

  // Slave model: drives its inputs on the falling edge from stable master outputs
  initial begin
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    clear_monitors();
    forever begin
      @(negedge clk);
      if (awvalid_o) begin
        aw_hi++;
        awready_i = (aw_wait >= cfg_aw_d);
        aw_wait++;
        if (awready_i) begin aw_hs++; cap_awaddr = awaddr_o; cap_awid = awid_o; end
      end else begin
        aw_wait = 0; awready_i = 1'b0;
      end
      if (wvalid_o) begin
        w_hi++;
        if (!wlast_o) wlast_bad++;
        wready_i = (w_wait >= cfg_w_d);
        w_wait++;
        if (wready_i) begin
          w_hs++; cap_wdata = wdata_o; cap_wstrb = wstrb_o; cap_wid = wid_o;
        end
      end else begin
        w_wait = 0; wready_i = 1'b0;
      end
      bid_i = cfg_bid; bresp_i = cfg_bresp;
      if (bready_o) begin
        bvalid_i = (b_wait >= cfg_b_d);
        b_wait++;
        if (bvalid_i) b_hs++;
      end else begin
        b_wait = 0; bvalid_i = cfg_stray;
      end
      if (arvalid_o) begin
        ar_hi++;
        arready_i = (ar_wait >= cfg_ar_d);
        ar_wait++;
        if (arready_i) begin ar_hs++; cap_araddr = araddr_o; cap_arid = arid_o; end
      end else begin
        ar_wait = 0; arready_i = 1'b0;
      end
      rid_i = cfg_rid; rdata_i = cfg_rdata;
      if (rready_o) begin
        rvalid_i = (r_wait >= cfg_r_d);
        r_wait++;
        if (rvalid_i) r_hs++;
      end else begin
        r_wait = 0; rvalid_i = cfg_stray;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int min_to(input int d);
    return (d + 1 > TO) ? TO : d + 1;
  endfunction

  // One command with the reference model's predictions computed from the slave delays
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int awd, input int wd, input int bd,
                        input int ard, input int rd, input logic [1:0] bresp,
                        input logic [3:0] bid, input logic [3:0] rid, input logic [31:0] rdat,
                        input int hold, input bit stray);
    int first, second, t_a, t_b, exp_lat, lat;
    bit to;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
    bit          got_rsp;

    cfg_aw_d = awd; cfg_w_d = wd; cfg_b_d = bd; cfg_ar_d = ard; cfg_r_d = rd;
    cfg_bresp = bresp; cfg_bid = bid; cfg_rid = rid; cfg_rdata = rdat; cfg_stray = stray;
    clear_monitors();

    first  = wr ? ((awd > wd) ? awd : wd) : ard;
    second = wr ? bd : rd;
    to = 1'b0; t_b = 0;
    if (first >= TO) begin
      to = 1'b1; t_a = TO;
    end else begin
      t_a = first + 1;
      if (second >= TO) begin to = 1'b1; t_b = TO; end
      else t_b = second + 1;
    end
    exp_lat = t_a + t_b + 2;
    if (to) exp_status = 2'b11;
    else if (wr) exp_status = (bid != ID) ? 2'b01 : ((bresp != 2'b00) ? 2'b10 : 2'b00);
    else exp_status = (rid != ID) ? 2'b01 : 2'b00;
    exp_rdata = (to || wr) ? 32'h0 : rdat;

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
    cmd_wdata_i = data; cmd_wstrb_i = strb;
    got_rsp = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_valid_i = 1'b0;
        check("cmd_ready_busy", cmd_ready_o, 0);
      end
      if (rsp_valid_o) begin got_rsp = 1'b1; lat = i; break; end
    end
    check("rsp_valid_seen", got_rsp, 1);
    check("latency", lat, exp_lat);
    check("rsp_status", rsp_status_o, exp_status);
    check("rsp_rdata", rsp_rdata_o, exp_rdata);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", rsp_valid_o, 1);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_drop", rsp_valid_o, 0);
    check("cmd_ready_back", cmd_ready_o, 1);

    check("aw_hs", aw_hs, (wr && awd < TO) ? 1 : 0);
    check("w_hs", w_hs, (wr && wd < TO) ? 1 : 0);
    check("b_hs", b_hs, (wr && !to) ? 1 : 0);
    check("ar_hs", ar_hs, (!wr && ard < TO) ? 1 : 0);
    check("r_hs", r_hs, (!wr && !to) ? 1 : 0);
    check("aw_hi", aw_hi, wr ? min_to(awd) : 0);
    check("w_hi", w_hi, wr ? min_to(wd) : 0);
    check("ar_hi", ar_hi, wr ? 0 : min_to(ard));
    check("wlast_with_wvalid", wlast_bad, 0);
    if (aw_hs > 0) begin
      check("awaddr", cap_awaddr, addr);
      check("awid", cap_awid, ID);
    end
    if (w_hs > 0) begin
      check("wdata", cap_wdata, data);
      check("wstrb", cap_wstrb, strb);
      check("wid", cap_wid, ID);
    end
    if (ar_hs > 0) begin
      check("araddr", cap_araddr, addr);
      check("arid", cap_arid, ID);
    end
    $display("txn %s addr=%08h status=%0d rdata=%08h lat=%0d (exp status=%0d lat=%0d)",
             wr ? "WR" : "RD", addr, rsp_status_o, rsp_rdata_o, lat, exp_status, exp_lat);
    cfg_stray = 1'b0;
  endtask

  initial begin
    int rsp_seen;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
    check("rst_wlast", wlast_o, 0);
    check("rst_addr", awaddr_o, 0);
    check("rst_ids", {awid_o, wid_o, arid_o}, {ID, ID, ID});
    check("rst_rsp", {rsp_rdata_o, rsp_status_o}, 0);
    areset = 1'b1;

    // Directed: basic write/read, delayed AW, error codes, timeout, boundary
    do_txn(1, 32'd3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, ID, ID, 32'h0, 1, 0);
    do_txn(0, 32'd3, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, ID, ID, 32'hDEADBEEF, 0, 0);
    do_txn(1, 32'd5, 32'h12345678, 4'h3, 5, 0, 0, 0, 0, 2'b00, ID, ID, 32'h0, 2, 0);
    do_txn(1, 32'd6, 32'hCAFEF00D, 4'hC, 0, 0, 1, 0, 0, 2'b10, ID, ID, 32'h0, 0, 0);
    do_txn(0, 32'd6, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, ID, 4'h7, 32'h55AA55AA, 0, 0);
    do_txn(0, 32'd2, 32'h0, 4'h0, 0, 0, 0, 20, 0, 2'b00, ID, ID, 32'hFFFFFFFF, 0, 0);
    do_txn(0, 32'd1, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, ID, ID, 32'h0BADCAFE, 0, 1);
    do_txn(1, 32'd4, 32'h0000AAAA, 4'h1, 0, 7, 7, 0, 0, 2'b00, ID, ID, 32'h0, 0, 0);
    do_txn(1, 32'd4, 32'h0000BBBB, 4'h2, 0, 0, 8, 0, 0, 2'b00, ID, ID, 32'h0, 0, 1);
    do_txn(1, 32'd7, 32'h0000CCCC, 4'h4, 7, 9, 0, 0, 0, 2'b00, 4'h2, ID, 32'h0, 0, 0);

    // Reset in the middle of a write while AW is still pending
    cfg_aw_d = 20; cfg_w_d = 20;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h10; cmd_wdata_i = 32'h99;
    cmd_wstrb_i = 4'hF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_awvalid", awvalid_o, 1);
    areset = 1'b0;
    #1;
    check("mid_rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
    check("mid_rst_cmd_ready", cmd_ready_o, 1);
    check("mid_rst_regs", {awaddr_o, wdata_o, wstrb_o, wlast_o}, 0);
    @(negedge clk);
    areset = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid_o) rsp_seen++;
    end
    check("no_rsp_after_reset", rsp_seen, 0);
    check("cmd_ready_after_reset", cmd_ready_o, 1);

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      bit          wr;
      int          d[5];
      logic [1:0]  bresp;
      logic [3:0]  bid, rid;
      wr = $urandom_range(0, 1) == 1;
      for (int k = 0; k < 5; k++)
        d[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
      bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bid   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : ID;
      rid   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : ID;
      do_txn(wr, $urandom, $urandom, 4'($urandom), d[0], d[1], d[2], d[3], d[4],
             bresp, bid, rid, $urandom, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m_axi_cmd_master.md
Name: m_axi_cmd_master

Overview:
- AXI initiator that turns single-word commands from a local controller into single-beat AXI writes/reads.
- Drives the register slave (7-word register bank with a CRC readback) from the master side.
- Returns one response per command, with the read data or a status code.
- Includes a watchdog so a stalled slave cannot hang the controller.

Parameters:
- DATA_WIDTH, 32, AXI data width; also command and response data width.
- ADDR_WIDTH, 32, AXI address width.
- TXN_ID, 4'h1, constant ID driven on awid_o, wid_o and arid_o; the expected bid_i/rid_i.
- TIMEOUT_CYCLES, 256, maximum cycles spent in any bus state before abort; minimum 2.

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous reset, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  DATA_WIDTH  write data
- cmd_wstrb_i  in  4  byte strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- rsp_status_o  out  2  00 OK, 01 ID mismatch, 10 slave error (bresp != 0), 11 timeout
- awid_o  out  4  write address ID
- awaddr_o  out  ADDR_WIDTH  write address
- awvalid_o  out  1  write address valid
- awready_i  in  1  write address ready
- wid_o  out  4  write data ID
- wdata_o  out  DATA_WIDTH  write data
- wstrb_o  out  4  write strobes
- wlast_o  out  1  last beat; always 1 while wvalid_o is high
- wvalid_o  out  1  write data valid
- wready_i  in  1  write data ready
- bid_i  in  4  response ID
- bresp_i  in  2  write response
- bvalid_i  in  1  response valid
- bready_o  out  1  response ready
- arid_o  out  4  read address ID
- araddr_o  out  ADDR_WIDTH  read address
- arvalid_o  out  1  read address valid
- arready_i  in  1  read address ready
- rid_i  in  4  read ID
- rdata_i  in  DATA_WIDTH  read data
- rstrb_i  in  4  read strobes; ignored
- rlast_i  in  1  read last; ignored (single beat)
- rvalid_i  in  1  read data valid
- rready_o  out  1  read data ready

Behaviour:
- Reset (async, areset low):
  - State IDLE; cmd_ready_o = 1.
  - All valids and readies low: awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o = 0.
  - Address, data, strobe and response registers = 0; wlast_o = 0; IDs = TXN_ID; watchdog = 0.
  - Reset mid-transaction aborts immediately; no response is issued.
- Every AXI output is a register. No combinational path from any input to any output.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready_o = 1; it is 0 in every other state.
  - Handshake with cmd_write_i = 1: latch addr/data/strb; awvalid_o = wvalid_o = wlast_o = 1 next cycle; go to WR.
  - Handshake with cmd_write_i = 0: latch addr; arvalid_o = 1 next cycle; go to RD_ADDR.
- WR:
  - AW and W complete independently, tracked by aw_done and w_done flags.
  - Each valid drops in the cycle after its own handshake.
  - When both are done (same cycle allowed), bready_o = 1 and go to WR_RESP.
  - Valids are never withdrawn before their handshake, except on timeout.
- WR_RESP:
  - On bvalid_i && bready_o: bready_o = 0.
  - Status priority: ID mismatch > bresp != 0 > OK.
  - Go to RESP.
- RD_ADDR: on arvalid_o && arready_i, arvalid_o = 0, rready_o = 1; go to RD_DATA.
- RD_DATA:
  - On rvalid_i && rready_o: latch rdata_i into rsp_rdata_o; status 01 if rid_i != TXN_ID, else 00.
  - rready_o = 0; go to RESP.
- RESP:
  - rsp_valid_o = 1, held until rsp_ready_i.
  - Then return to IDLE; cmd_ready_o is high the following cycle, so there is no back-to-back command in the accept cycle.
- Watchdog:
  - Counter cleared on entry to WR, WR_RESP, RD_ADDR and RD_DATA; increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES - 1 with no completing handshake: drop all valids/readies, status 11, rdata 0, go to RESP.
  - A handshake landing in that same cycle wins over the timeout.
  - Abort is a deliberate protocol break, used for bring-up only.
- Latency, zero-wait slave:
  - Write: command accept to rsp_valid_o = 4 cycles (aw/w 1, b 1, resp 1, plus register stage).
  - Read: command accept to rsp_valid_o = 4 cycles.
- Stray bvalid_i or rvalid_i outside the matching state is ignored; the corresponding ready stays low.

Decomposition:
- Package m_axi_cmd_pkg holds:
  - state enum;
  - status constants ST_OK = 2'b00, ST_IDERR = 2'b01, ST_SLVERR = 2'b10, ST_TIMEOUT = 2'b11;
  - AXI resp constants OKAY = 2'b00, SLVERR = 2'b10.
- One sub-module, axi_watchdog: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write addr 3, data 32'hDEADBEEF, strb 4'hF; slave awready = wready = 1, bresp 0, bid 1 -> one AW and one W handshake carrying those values with wlast_o = 1; rsp_status 00 four cycles after accept.
- Read addr 3 after the write above, slave returns 32'hDEADBEEF with rid 1 -> rsp_rdata_o = 32'hDEADBEEF, status 00.
- awready delayed 5 cycles, wready immediate -> wvalid_o drops after 1 cycle, awvalid_o is held 6 cycles; a single B handshake follows; status 00.
- Slave returns bresp = 2'b10, then a separate read returns rid = 4'h7 -> status 10 for the write, 01 for the read.
- TIMEOUT_CYCLES = 8, arready held at 0 -> arvalid_o drops after 8 cycles; rsp_status 11, rdata 0; the next command is accepted normally.
- areset pulsed low mid-WR with awvalid_o high -> all outputs at reset values immediately; no rsp_valid_o pulse; cmd_ready_o = 1 after release.
